fetch_ctrl: RTL

Instruction-fetch stage controller of the 5-stage pipeline. It owns the PC register, the instruction-memory request/response handshake and the IF/ID pipeline register. It is the consumer of the load-use hazard unit's `PCWr` / `IF_ID_Wr` / `stall` outputs and of the EX-stage branch/jump redirect. It drives the ID/EX bubble control and holds a fetched instruction while the front end is stalled.

---
 rtl/fetch_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch stage controller.
//
// Owns the PC, the single-outstanding instruction-memory handshake and the
// IF/ID pipeline register. Consumes the hazard unit's PCWr / IF_ID_Wr / stall
// and the EX-stage redirect; drives the ID/EX bubble control.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   PCWr, IF_ID_Wr, stall     hazard unit controls (stall[1] reserved)
//   redirect_valid/_pc        taken branch / jump from EX
//   imem_req/_addr/_ready     fetch request channel
//   imem_rvalid/_rdata        fetch response channel
//   IF_ID_PC/_inst/_valid     IF/ID pipeline register
//   ID_EX_flush               combinational bubble request into ID/EX
//   perf_stall_cnt/_flush_cnt performance counters
//
// Build option: define FETCH_PERF_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | request outstanding to memory at pc (unless redirecting)
// WAIT  | request accepted, waiting for the response
// HOLD  | response captured in hold buffer, front end stalled
// DROP  | redirect seen while waiting; next response is discarded

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWr,
    input  logic        IF_ID_Wr,
    input  logic [1:0]  stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid,
    output logic        ID_EX_flush,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_inst, hold_nxt;
    logic        deliver;
    logic [31:0] deliver_inst;
    logic        advance;
    logic [31:0] redirect_tgt;
    logic        unused_bits;

    assign advance      = PCWr & IF_ID_Wr;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign unused_bits  = ^{stall[1], redirect_pc[1:0]};

    assign imem_addr   = pc;
    assign ID_EX_flush = stall[0] | redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            hold_inst <= NOP_INST;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            hold_inst <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        hold_nxt     = hold_inst;
        deliver      = 1'b0;
        deliver_inst = hold_inst;
        imem_req     = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = ~redirect_valid;
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                end else if (imem_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = imem_rvalid ? S_FETCH : S_DROP;
                end else if (imem_rvalid) begin
                    if (advance) begin
                        deliver      = 1'b1;
                        deliver_inst = imem_rdata;
                        pc_nxt       = pc + 32'd4;
                        state_nxt    = S_FETCH;
                    end else begin
                        hold_nxt  = imem_rdata;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = S_FETCH;
                end else if (advance) begin
                    deliver   = 1'b1;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                end
                if (imem_rvalid) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Redirect flushes IF/ID even while the hazard unit is holding it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF_ID_PC    <= RESET_PC;
            IF_ID_inst  <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else if (redirect_valid) begin
            IF_ID_inst  <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else if (IF_ID_Wr) begin
            if (deliver) begin
                IF_ID_PC    <= pc;
                IF_ID_inst  <= deliver_inst;
                IF_ID_valid <= 1'b1;
            end else begin
                IF_ID_inst  <= NOP_INST;
                IF_ID_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!IF_ID_Wr) stall_cnt <= stall_cnt + 32'd1;
            if (redirect_valid) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
